// File: rtl/regbank_checker.sv
// End-of-run register bank checker: counts check_cycles_i clocks after start,
// halts the core, scans every register and reports mismatches against expected values.
module regbank_checker #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned NREGS  = 16,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  check_cycles_i,
    output logic              halt_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [DATA_W-1:0] exp_data_i,
    input  logic              exp_valid_i,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_err_idx_o,
    output logic [DATA_W-1:0] first_err_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cc_q, cc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]     sidx_q, sidx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                halt_q, halt_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   fidx_q, fidx_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                mismatch;

    // sidx_q counts SCAN cycles; in cycle s the data for address s-1 is present.
    assign mismatch = (sidx_q != '0) && exp_valid_i && (rf_data_i != exp_data_i);

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        cnt_d   = cnt_q;
        sidx_d  = sidx_q;
        addr_d  = addr_q;
        halt_d  = halt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    cc_d    = check_cycles_i;
                    cnt_d   = '0;
                    sidx_d  = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fdata_d = '0;
                    if (check_cycles_i == '0) begin
                        state_d = S_SCAN;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = S_COUNT;
                        halt_d  = 1'b0;
                    end
                end
            end
            S_COUNT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == cc_q - CNT_W'(1)) begin
                    state_d = S_SCAN;
                    halt_d  = 1'b1;
                    sidx_d  = '0;
                    addr_d  = '0;
                end
            end
            S_SCAN: begin
                sidx_d = sidx_q + (ADDR_W+1)'(1);
                if (addr_q != ADDR_W'(NREGS - 1)) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (mismatch) begin
                    err_d = err_q + (ADDR_W+1)'(1);
                    if (err_q == '0) begin
                        fidx_d  = ADDR_W'(sidx_q - (ADDR_W+1)'(1));
                        fdata_d = rf_data_i;
                    end
                end
                if (sidx_q == (ADDR_W+1)'(NREGS)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cc_q    <= '0;
            cnt_q   <= '0;
            sidx_q  <= '0;
            addr_q  <= '0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            cnt_q   <= cnt_d;
            sidx_q  <= sidx_d;
            addr_q  <= addr_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
        end
    end

    assign halt_o           = halt_q;
    assign rf_addr_o        = addr_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_idx_o  = fidx_q;
    assign first_err_data_o = fdata_q;

endmodule

// File: tb/tb_regbank_checker.sv
// Directed bench for regbank_checker: a behavioural register bank with 1-cycle
// read latency feeds rf_data/exp_data; results are checked against hand values.
module tb_regbank_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] check_cycles;
    logic        halt;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [15:0] first_err_data;

    logic [15:0] rf_mem  [16];
    logic [15:0] exp_mem [16];
    logic        expv_mem[16];

    int checks   = 0;
    int failures = 0;

    regbank_checker #(.DATA_W(16), .NREGS(16), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .check_cycles_i   (check_cycles),
        .halt_o           (halt),
        .rf_addr_o        (rf_addr),
        .rf_data_i        (rf_data),
        .exp_data_i       (exp_data),
        .exp_valid_i      (exp_valid),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err_count),
        .first_err_idx_o  (first_err_idx),
        .first_err_data_o (first_err_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rf_data   <= rf_mem[rf_addr];
        exp_data  <= exp_mem[rf_addr];
        exp_valid <= expv_mem[rf_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic fill_match();
        for (int i = 0; i < 16; i++) begin
            rf_mem[i]   = 16'(4096 + i * 273);
            exp_mem[i]  = rf_mem[i];
            expv_mem[i] = 1'b1;
        end
    endtask

    // Start pulse, then count sampled cycles to halt (n) and from halt to done (m).
    // With pulse set, start is toggled during COUNT and SCAN to show it is ignored.
    task automatic run(input logic [15:0] cc, input bit pulse, output int n, output int m);
        @(negedge clk);
        start = 1'b1;
        check_cycles = cc;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!halt && n < 5000) begin
            @(negedge clk);
            n++;
            if (pulse && n == 4) start = 1'b1;
            if (pulse && n == 6) start = 1'b0;
        end
        start = 1'b0;
        m = 0;
        while (!done && m < 100) begin
            @(negedge clk);
            m++;
            if (pulse && m == 3) start = 1'b1;
            if (pulse && m == 5) start = 1'b0;
        end
        start = 1'b0;
    endtask

    int n, m;

    initial begin
        start = 1'b0;
        check_cycles = '0;
        fill_match();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_fdata", 32'(first_err_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Match run with start pulses during COUNT and SCAN
        run(16'd900, 1'b1, n, m);
        check("t1_halt_lat", 32'(n), 32'd900);
        check("t1_done_lat", 32'(m), 32'd17);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_halt_held", 32'(halt), 32'd1);
        check("t1_addr_hold", 32'(rf_addr), 32'd15);

        // Re-arm from DONE
        @(negedge clk);
        start = 1'b1;
        check_cycles = 16'd10;
        @(negedge clk);
        start = 1'b0;
        check("t6_done_fall", 32'(done), 32'd0);
        check("t6_pass_fall", 32'(pass), 32'd0);
        check("t6_halt_fall", 32'(halt), 32'd0);
        n = 0;
        while (!halt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_halt_lat", 32'(n), 32'd10);
        m = 0;
        while (!done && m < 100) begin
            @(negedge clk);
            m++;
        end
        check("t6_done_lat", 32'(m), 32'd17);
        check("t6_pass", 32'(pass), 32'd1);

        // Two mismatches
        rf_mem[3] = 16'd7;
        exp_mem[3] = 16'd5;
        rf_mem[6] = 16'hFFFF;
        exp_mem[6] = 16'd0;
        run(16'd5, 1'b0, n, m);
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err_count), 32'd2);
        check("t2_fidx", 32'(first_err_idx), 32'd3);
        check("t2_fdata", 32'(first_err_data), 32'h0007);
        check("t2_pass", 32'(pass), 32'd0);

        // Masked R3 mismatch
        fill_match();
        rf_mem[3] = 16'd7;
        exp_mem[3] = 16'd5;
        expv_mem[3] = 1'b0;
        run(16'd3, 1'b0, n, m);
        check("t3_err", 32'(err_count), 32'd0);
        check("t3_pass", 32'(pass), 32'd1);

        // Boundary registers R0 and R15
        fill_match();
        rf_mem[15] = 16'hBEEF;
        rf_mem[0] = 16'h1234;
        run(16'd1, 1'b0, n, m);
        check("tb_halt_lat", 32'(n), 32'd1);
        check("tb_err", 32'(err_count), 32'd2);
        check("tb_fidx", 32'(first_err_idx), 32'd0);
        check("tb_fdata", 32'(first_err_data), 32'h1234);

        // Zero cycles, start pulses during SCAN
        fill_match();
        rf_mem[9] = 16'h0A0A;
        @(negedge clk);
        start = 1'b1;
        check_cycles = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("t4_halt", 32'(halt), 32'd1);
        check("t4_addr0", 32'(rf_addr), 32'd0);
        m = 0;
        while (!done && m < 100) begin
            @(negedge clk);
            m++;
            if (m == 3) start = 1'b1;
            if (m == 8) start = 1'b0;
        end
        start = 1'b0;
        check("t4_done_lat", 32'(m), 32'd17);
        check("t4_err", 32'(err_count), 32'd1);
        check("t4_fidx", 32'(first_err_idx), 32'd9);

        // Reset during COUNT
        @(negedge clk);
        start = 1'b1;
        check_cycles = 16'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5c_halt", 32'(halt), 32'd0);
        check("t5c_done", 32'(done), 32'd0);
        check("t5c_err", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t5c_idle_halt", 32'(halt), 32'd0);

        // Reset during SCAN with errors already counted
        fill_match();
        rf_mem[3] = 16'd7;
        exp_mem[3] = 16'd5;
        rf_mem[6] = 16'hFFFF;
        exp_mem[6] = 16'd0;
        @(negedge clk);
        start = 1'b1;
        check_cycles = 16'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!halt && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("t5s_err_pre", 32'(err_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5s_halt", 32'(halt), 32'd0);
        check("t5s_err", 32'(err_count), 32'd0);
        check("t5s_done", 32'(done), 32'd0);
        check("t5s_addr", 32'(rf_addr), 32'd0);
        check("t5s_fidx", 32'(first_err_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t5s_idle_done", 32'(done), 32'd0);
        check("t5s_idle_halt", 32'(halt), 32'd0);

        // Still usable after reset
        fill_match();
        run(16'd3, 1'b0, n, m);
        check("t5_post_halt_lat", 32'(n), 32'd3);
        check("t5_post_pass", 32'(pass), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
